led_fade_top: RTL and testbench

Top-level LED breathing block: one LED output fades smoothly from off to full on and back to off, repeating forever with no external control. A triangle-wave brightness generator drives a fixed-period PWM modulator. The block sits directly at the FPGA pins, with the board oscillator on `clk` (nominally 12 MHz) and the LED on `LED`.

---
 rtl/led_fade_top.sv | 168 ++++++++++++++++
 tb/tb_led_fade_top.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/led_fade_top.sv
// -----------------------------------------------------------------------------
// led_fade_top
//   LED breathing generator. A triangle-wave brightness level ("duty") ramps
//   from 0 up to PWM_INTERVAL and back down, one DUTY_STEP per step tick, and
//   drives a fixed-period PWM modulator whose output is the LED pin.
//
// Parameters
//   PWM_INTERVAL   PWM period in clk cycles (>= 2)
//   STEPS          duty increments per half fade
//   STEP_INTERVAL  clk cycles between duty updates
//
// Ports
//   clk    in   system clock, rising-edge logic
//   rst_n  in   asynchronous active-low reset
//   LED    out  registered PWM LED drive
//
// Build option
//   FADE_ACTIVE_LOW_EN  defined: LED is active-low (off level 1, also in reset)
//                       undefined: LED is active-high (off level 0)
// -----------------------------------------------------------------------------
module led_fade_top #(
    parameter int PWM_INTERVAL  = 1200,
    parameter int STEPS         = 200,
    parameter int STEP_INTERVAL = 30000
) (
    input  logic clk,
    input  logic rst_n,
    output logic LED
);

    localparam int DUTY_STEP = PWM_INTERVAL / STEPS;
    localparam int DW        = $clog2(PWM_INTERVAL + 1);
    localparam int SW        = $clog2(STEP_INTERVAL + 1);

    // One extra bit on the ramp-up sum so the clamp compare can never wrap.
    localparam logic [DW:0]   DUTY_STEP_X = (DW+1)'(DUTY_STEP);
    localparam logic [DW:0]   PWM_MAX_X   = (DW+1)'(PWM_INTERVAL);
    localparam logic [DW-1:0] DUTY_STEP_N = DW'(DUTY_STEP);
    localparam logic [DW-1:0] PWM_MAX     = DW'(PWM_INTERVAL);
    localparam logic [DW-1:0] PWM_LAST    = DW'(PWM_INTERVAL - 1);
    localparam logic [SW-1:0] STEP_LAST   = SW'(STEP_INTERVAL - 1);

`ifdef FADE_ACTIVE_LOW_EN
    localparam logic LED_OFF = 1'b1;
`else
    localparam logic LED_OFF = 1'b0;
`endif

    if (DUTY_STEP < 1) begin : g_bad_duty_step
        $error("led_fade_top: PWM_INTERVAL / STEPS must be at least 1");
    end

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [SW-1:0]   step_cnt_r;
    logic            step_tick_s;
    logic [DW-1:0]   duty_r;
    logic [DW-1:0]   duty_nxt_s;
    logic [DW:0]     duty_sum_s;
    logic [DW-1:0]   pwm_cnt_r;
    logic [DW-1:0]   duty_active_r;
    logic            pwm_wrap_s;
    logic            pwm_on_s;
    logic            led_nxt_s;
    logic            led_r;

    assign step_tick_s = (step_cnt_r == STEP_LAST);
    assign pwm_wrap_s  = (pwm_cnt_r == PWM_LAST);
    assign duty_sum_s  = {1'b0, duty_r} + DUTY_STEP_X;

    // Step timer: free-running 0..STEP_INTERVAL-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_r <= {SW{1'b0}};
        end else if (step_tick_s) begin
            step_cnt_r <= {SW{1'b0}};
        end else begin
            step_cnt_r <= step_cnt_r + SW'(1);
        end
    end

    // Fade FSM state and duty registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= RAMP_UP;
            duty_r  <= {DW{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            duty_r  <= duty_nxt_s;
        end
    end

    // Fade FSM next state: the turnaround tick writes the clamped extreme and
    // switches direction together, so each extreme lasts one step interval.
    always_comb begin
        state_nxt_s = state_r;
        duty_nxt_s  = duty_r;
        if (step_tick_s) begin
            case (state_r)
                RAMP_UP: begin
                    if (duty_sum_s >= PWM_MAX_X) begin
                        duty_nxt_s  = PWM_MAX;
                        state_nxt_s = RAMP_DOWN;
                    end else begin
                        duty_nxt_s  = duty_sum_s[DW-1:0];
                    end
                end
                RAMP_DOWN: begin
                    if ({1'b0, duty_r} <= DUTY_STEP_X) begin
                        duty_nxt_s  = {DW{1'b0}};
                        state_nxt_s = RAMP_UP;
                    end else begin
                        duty_nxt_s  = duty_r - DUTY_STEP_N;
                    end
                end
                default: begin
                    duty_nxt_s  = {DW{1'b0}};
                    state_nxt_s = RAMP_UP;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
            duty_nxt_s  = duty_r;
        end
    end

    // PWM counter and period-aligned duty capture; the capture uses the duty
    // value from before any coincident step update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_cnt_r     <= {DW{1'b0}};
            duty_active_r <= {DW{1'b0}};
        end else if (pwm_wrap_s) begin
            pwm_cnt_r     <= {DW{1'b0}};
            duty_active_r <= duty_r;
        end else begin
            pwm_cnt_r     <= pwm_cnt_r + DW'(1);
            duty_active_r <= duty_active_r;
        end
    end

    // Compare and output polarity.
    always_comb begin
        pwm_on_s = (pwm_cnt_r < duty_active_r);
`ifdef FADE_ACTIVE_LOW_EN
        led_nxt_s = ~pwm_on_s;
`else
        led_nxt_s = pwm_on_s;
`endif
    end

    // Registered LED drive; reset forces the off level immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led_r <= LED_OFF;
        end else begin
            led_r <= led_nxt_s;
        end
    end

    assign LED = led_r;

endmodule

// File: tb/tb_led_fade_top.sv
// Bench for led_fade_top. Two instances run side by side from one clock and
// reset: A (PWM 10, STEPS 5, STEP_INTERVAL 20) with an exact triangle, and
// B (PWM 11, STEPS 5, STEP_INTERVAL 20) whose extremes clamp. The reference
// model is closed-form in the number of rising edges since reset release.
module tb_led_fade_top;

    localparam int SI = 20;
    localparam int PA = 10;
    localparam int PB = 11;
    localparam int DS = 2;

`ifdef FADE_ACTIVE_LOW_EN
    localparam bit ACT_LOW = 1'b1;
`else
    localparam bit ACT_LOW = 1'b0;
`endif

    logic clk;
    logic rst_n;
    logic led_a;
    logic led_b;

    int n_checks;
    int n_fail;
    int e;          // rising edges since reset release
    int tri_a[$];   // duty levels over one full triangle, one entry per tick
    int tri_b[$];

    led_fade_top #(.PWM_INTERVAL(PA), .STEPS(5), .STEP_INTERVAL(SI)) dut_a (
        .clk(clk), .rst_n(rst_n), .LED(led_a)
    );
    led_fade_top #(.PWM_INTERVAL(PB), .STEPS(5), .STEP_INTERVAL(SI)) dut_b (
        .clk(clk), .rst_n(rst_n), .LED(led_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Triangle: 0, then add DS clamped at P, then subtract DS clamped at 0,
    // stopping before the trough repeats.
    task automatic build_tri(input int sel, input int p);
        int d;
        d = 0;
        if (sel == 0) tri_a.push_back(0); else tri_b.push_back(0);
        while (d < p) begin
            d = (d + DS > p) ? p : d + DS;
            if (sel == 0) tri_a.push_back(d); else tri_b.push_back(d);
        end
        while (d > 0) begin
            d = (d - DS < 0) ? 0 : d - DS;
            if (d > 0) begin
                if (sel == 0) tri_a.push_back(d); else tri_b.push_back(d);
            end
        end
    endtask

    function automatic int per(input int sel);
        return (sel == 0) ? PA : PB;
    endfunction

    function automatic int duty_after(input int sel, input int k);
        int n;
        if (k < 0) return 0;
        n = k / SI;
        if (sel == 0) return tri_a[n % tri_a.size()];
        return tri_b[n % tri_b.size()];
    endfunction

    // Duty in force during the PWM period containing cycle k: the duty seen
    // just before that period began.
    function automatic int active_after(input int sel, input int k);
        int m;
        m = k / per(sel);
        if (m == 0) return 0;
        return duty_after(sel, m * per(sel) - 1);
    endfunction

    function automatic logic led_after(input int sel, input int k);
        logic on;
        if (k == 0) return ACT_LOW;
        on = ((k - 1) % per(sel)) < active_after(sel, k - 1);
        return ACT_LOW ? ~on : on;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d (edge %0d)", tag, obs, exp, e);
        end
    endtask

    task automatic check_reset();
        check("rst_led_a", 32'(led_a), 32'(ACT_LOW));
        check("rst_led_b", 32'(led_b), 32'(ACT_LOW));
        check("rst_step_cnt", 32'(dut_a.step_cnt_r), 32'd0);
        check("rst_pwm_cnt", 32'(dut_a.pwm_cnt_r), 32'd0);
        check("rst_duty", 32'(dut_a.duty_r), 32'd0);
        check("rst_duty_active", 32'(dut_a.duty_active_r), 32'd0);
        check("rst_duty_b", 32'(dut_b.duty_r), 32'd0);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            check("led_a", 32'(led_a), 32'(led_after(0, e)));
            check("led_b", 32'(led_b), 32'(led_after(1, e)));
            check("duty_a", 32'(dut_a.duty_r), 32'(duty_after(0, e)));
            check("duty_b", 32'(dut_b.duty_r), 32'(duty_after(1, e)));
        end
    endtask

    // Assert reset mid-cycle, check it took effect before any clock edge,
    // hold, then release on a falling edge.
    task automatic pulse_reset(input int hold);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset();
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_reset();
        end
        rst_n = 1'b1;
        e = 0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        e        = 0;
        rst_n    = 1'b1;
        build_tri(0, PA);
        build_tri(1, PB);

        // Power-up reset, five cycles, asserted asynchronously.
        @(negedge clk);
        pulse_reset(5);

        // Ramp up, turnaround and more than two full triangles of A.
        run(430);

        // Reset during RAMP_DOWN while A's duty is 6, then restart from zero.
        @(negedge clk);
        pulse_reset(1);
        run(140 + $urandom_range(0, 19));
        check("duty_before_mid_reset", 32'(dut_a.duty_r), 32'd6);
        pulse_reset(1);
        run(120);

        // Random run lengths with random reset pulses.
        for (int k = 0; k < 3; k++) begin
            run($urandom_range(30, 300));
            pulse_reset($urandom_range(1, 3));
        end
        run(250);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
